// File: rtl/branch_resolve_queue.sv
// Purpose: in-order queue of predicted conditional branches between fetch and execute; drives the predictor update port and flags mispredictions.
// Latency: resolve in cycle N gives upd_* / mispredict in cycle N+1; a push in cycle N is visible on count/full/empty in cycle N+1.
// Backpressure: none; a push while full (with no pop) is dropped and sets err_ovf, a resolve while empty is ignored and sets err_udf.
//
// Ports:
//   clk, arst_n                   clock, synchronous active-low reset
//   push, push_addr, push_pred    fetch-side enqueue of {predictor index, prediction}
//   resolve, was_taken, jumped    execute-side pop of the oldest branch with its outcome
//   upd_branch/addr/taken/jumped  registered predictor update port
//   mispredict                    registered one-cycle pulse on a wrong prediction
//   full, empty, count            registered queue occupancy
//   mispred_cnt, resolved_cnt     saturating statistics
//   err_ovf, err_udf              sticky error flags
module branch_resolve_queue #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic [LOWER-1:0]         push_addr,
    input  logic                     push_pred,
    input  logic                     resolve,
    input  logic                     was_taken,
    input  logic                     jumped,
    output logic                     upd_branch,
    output logic [LOWER-1:0]         upd_addr,
    output logic                     upd_taken,
    output logic                     upd_jumped,
    output logic                     mispredict,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic [CNT_W-1:0]         resolved_cnt,
    output logic                     err_ovf,
    output logic                     err_udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [LOWER-1:0] addr_mem [DEPTH];
    logic             pred_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    cnt_q;

    logic do_pop;
    logic actual;
    logic mis;
    logic push_ok;
    logic push_ovf;

    always_comb begin
        do_pop   = resolve && (cnt_q != '0);
        actual   = was_taken | jumped;
        mis      = do_pop && (pred_mem[rd_ptr] != actual);
        // A push alongside a mispredicting resolve is wrong-path: discard silently.
        // Otherwise it fits if there is room or the head leaves this same cycle.
        push_ok  = push && !mis && ((cnt_q != DEPTH_C) || do_pop);
        push_ovf = push && !mis && !push_ok;
    end

    always_ff @(posedge clk) begin
        if (arst_n && push_ok) begin
            addr_mem[wr_ptr] <= push_addr;
            pred_mem[wr_ptr] <= push_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt_q        <= '0;
            upd_branch   <= 1'b0;
            upd_addr     <= '0;
            upd_taken    <= 1'b0;
            upd_jumped   <= 1'b0;
            mispredict   <= 1'b0;
            mispred_cnt  <= '0;
            resolved_cnt <= '0;
            err_ovf      <= 1'b0;
            err_udf      <= 1'b0;
        end else begin
            upd_branch <= do_pop;
            mispredict <= mis;
            if (do_pop) begin
                upd_addr   <= addr_mem[rd_ptr];
                upd_taken  <= was_taken;
                upd_jumped <= jumped;
                if (resolved_cnt != '1) begin
                    resolved_cnt <= resolved_cnt + 1'b1;
                end
            end

            if (mis) begin
                // Everything younger than the popped entry is wrong-path.
                rd_ptr <= wr_ptr;
                cnt_q  <= '0;
                if (mispred_cnt != '1) begin
                    mispred_cnt <= mispred_cnt + 1'b1;
                end
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, do_pop})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end

            if (push_ovf) begin
                err_ovf <= 1'b1;
            end
            if (resolve && (cnt_q == '0)) begin
                err_udf <= 1'b1;
            end
        end
    end

    assign count = cnt_q;
    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    localparam int LOWER = 5;
    localparam int DEPTH = 4;
    localparam int SAT_W = 2;

    typedef struct packed {
        logic [LOWER-1:0] addr;
        logic             pred;
    } ent_t;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             push;
    logic [LOWER-1:0] push_addr;
    logic             push_pred;
    logic             resolve;
    logic             was_taken;
    logic             jumped;

    logic             a_ub, a_ut, a_uj, a_mis, a_full, a_empty, a_ovf, a_udf;
    logic [LOWER-1:0] a_ua;
    logic [2:0]       a_cnt;
    logic [15:0]      a_mc, a_rc;

    logic             s_ub, s_ut, s_uj, s_mis, s_full, s_empty, s_ovf, s_udf;
    logic [LOWER-1:0] s_ua;
    logic [2:0]       s_cnt;
    logic [SAT_W-1:0] s_mc, s_rc;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a plain queue of in-flight branches plus expected outputs.
    ent_t             q[$];
    bit               m_ub, m_ut, m_uj, m_mis, m_ovf, m_udf;
    logic [LOWER-1:0] m_ua;
    int               m_mc, m_rc;

    always #5 clk = ~clk;

    branch_resolve_queue #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .push(push), .push_addr(push_addr),
        .push_pred(push_pred), .resolve(resolve), .was_taken(was_taken),
        .jumped(jumped), .upd_branch(a_ub), .upd_addr(a_ua), .upd_taken(a_ut),
        .upd_jumped(a_uj), .mispredict(a_mis), .full(a_full), .empty(a_empty),
        .count(a_cnt), .mispred_cnt(a_mc), .resolved_cnt(a_rc),
        .err_ovf(a_ovf), .err_udf(a_udf)
    );

    branch_resolve_queue #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .arst_n(arst_n), .push(push), .push_addr(push_addr),
        .push_pred(push_pred), .resolve(resolve), .was_taken(was_taken),
        .jumped(jumped), .upd_branch(s_ub), .upd_addr(s_ua), .upd_taken(s_ut),
        .upd_jumped(s_uj), .mispredict(s_mis), .full(s_full), .empty(s_empty),
        .count(s_cnt), .mispred_cnt(s_mc), .resolved_cnt(s_rc),
        .err_ovf(s_ovf), .err_udf(s_udf)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, " upd_branch"},   32'(a_ub),    32'(m_ub));
        chk({tag, " upd_addr"},     32'(a_ua),    32'(m_ua));
        chk({tag, " upd_taken"},    32'(a_ut),    32'(m_ut));
        chk({tag, " upd_jumped"},   32'(a_uj),    32'(m_uj));
        chk({tag, " mispredict"},   32'(a_mis),   32'(m_mis));
        chk({tag, " count"},        32'(a_cnt),   n);
        chk({tag, " full"},         32'(a_full),  32'(n == DEPTH));
        chk({tag, " empty"},        32'(a_empty), 32'(n == 0));
        chk({tag, " mispred_cnt"},  32'(a_mc),    sat(m_mc, 65535));
        chk({tag, " resolved_cnt"}, 32'(a_rc),    sat(m_rc, 65535));
        chk({tag, " err_ovf"},      32'(a_ovf),   32'(m_ovf));
        chk({tag, " err_udf"},      32'(a_udf),   32'(m_udf));
        chk({tag, " sat upd"},      32'({s_ub, s_ua, s_ut, s_uj, s_mis}),
                                    32'({m_ub, m_ua, m_ut, m_uj, m_mis}));
        chk({tag, " sat status"},   32'({s_cnt, s_full, s_empty, s_ovf, s_udf}),
                                    32'({3'(n), n == DEPTH, n == 0, m_ovf, m_udf}));
        chk({tag, " sat mispred_cnt"},  32'(s_mc), sat(m_mc, 3));
        chk({tag, " sat resolved_cnt"}, 32'(s_rc), sat(m_rc, 3));
    endtask

    task automatic model(input bit rst, input bit p, input logic [LOWER-1:0] pa,
                         input bit pp, input bit r, input bit wt, input bit jm);
        int   n;
        bit   pop;
        bit   mis;
        ent_t head;
        ent_t e;
        if (rst) begin
            q.delete();
            m_ub = 0; m_ua = '0; m_ut = 0; m_uj = 0; m_mis = 0;
            m_mc = 0; m_rc = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        n   = q.size();
        pop = r && (n > 0);
        mis = 0;
        m_ub = pop;
        if (pop) begin
            head = q.pop_front();
            m_ua = head.addr;
            m_ut = wt;
            m_uj = jm;
            m_rc++;
            mis = (head.pred != (wt | jm));
            if (mis) begin
                m_mc++;
                q.delete();
            end
        end
        if (r && n == 0) m_udf = 1;
        m_mis = mis;
        if (p && !mis) begin
            if (n < DEPTH || pop) begin
                e.addr = pa;
                e.pred = pp;
                q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit p,
                        input logic [LOWER-1:0] pa, input bit pp,
                        input bit r, input bit wt, input bit jm);
        @(negedge clk);
        arst_n    = !rst;
        push      = p;
        push_addr = pa;
        push_pred = pp;
        resolve   = r;
        was_taken = wt;
        jumped    = jm;
        model(rst, p, pa, pp, r, wt, jm);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1, 1, 5'd17, 1, 1, 1, 0);
    endtask

    initial begin
        bit               p, pp, r, wt, jm, rst;
        logic [LOWER-1:0] pa;
        arst_n = 0; push = 0; push_addr = '0; push_pred = 0;
        resolve = 0; was_taken = 0; jumped = 0;

        do_reset("reset0");

        // Build non-zero counters and a full queue, then reset over it.
        step("pre_push", 0, 1, 5'd6, 0, 0, 0, 0);
        step("pre_mis",  0, 0, 5'd0, 0, 1, 1, 0);
        step("pre_ok",   0, 1, 5'd8, 1, 0, 0, 0);
        step("pre_ok_r", 0, 0, 5'd0, 0, 1, 1, 0);
        for (int i = 0; i < DEPTH; i++) step("pre_fill", 0, 1, 5'(i + 10), 1, 0, 0, 0);
        do_reset("reset_full");

        // Correct predictions, back-to-back strobes.
        step("ok_push3", 0, 1, 5'd3, 1, 0, 0, 0);
        step("ok_push7", 0, 1, 5'd7, 0, 0, 0, 0);
        step("ok_res3",  0, 0, 5'd0, 0, 1, 1, 0);
        step("ok_res7",  0, 0, 5'd0, 0, 1, 0, 0);
        step("ok_idle",  0, 0, 5'd0, 0, 0, 0, 0);

        // Misprediction flush with a wrong-path push in the same cycle.
        do_reset("reset_mis");
        step("mis_push1", 0, 1, 5'd1, 0, 0, 0, 0);
        step("mis_push2", 0, 1, 5'd2, 1, 0, 0, 0);
        step("mis_push4", 0, 1, 5'd4, 1, 0, 0, 0);
        step("mis_res",   0, 1, 5'd9, 1, 1, 0, 1);
        step("mis_after", 0, 0, 5'd0, 0, 1, 0, 0);

        // Fill, then resolve+push eight times across pointer wrap, then drain.
        do_reset("reset_wrap");
        for (int i = 0; i < DEPTH; i++) step("wrap_fill", 0, 1, 5'(i + 1), i[0], 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            pp = q[0].pred;
            step("wrap_rp", 0, 1, 5'(i + 20), !pp, 1, pp, 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pp = q[0].pred;
            step("wrap_drain", 0, 0, 5'd0, 0, 1, 0, pp);
        end

        // Overflow while full leaves contents intact; underflow gives no strobe.
        for (int i = 0; i < DEPTH; i++) step("err_fill", 0, 1, 5'(i + 5), 1, 0, 0, 0);
        step("err_ovf", 0, 1, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step("err_drain", 0, 0, 5'd0, 0, 1, 1, 0);
        step("err_udf", 0, 0, 5'd0, 0, 1, 1, 0);

        // Five mispredictions: the narrow instance saturates at 3.
        do_reset("reset_sat");
        for (int i = 0; i < 5; i++) begin
            step("sat_push", 0, 1, 5'(i), 0, 0, 0, 0);
            step("sat_mis",  0, 0, 5'd0, 0, 1, 1, 0);
        end

        // Randomized traffic, mostly correct predictions, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            p   = $urandom_range(0, 1);
            pa  = 5'($urandom);
            pp  = $urandom_range(0, 1);
            r   = ($urandom_range(0, 2) != 0);
            wt  = $urandom_range(0, 1);
            jm  = $urandom_range(0, 1);
            if (q.size() > 0 && $urandom_range(0, 4) != 0) begin
                if (q[0].pred) begin
                    if (!wt && !jm) wt = 1;
                end else begin
                    wt = 0;
                    jm = 0;
                end
            end
            step("rand", rst, p, pa, pp, r, wt, jm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every conditional branch between fetch-time prediction and execute-time resolution, in program order. Fetch pushes the branch-history-table index and prediction bit; execute pops the oldest entry with the actual outcome. The block then drives the branch-history-table update port (address, taken, jumped, branch strobe) one cycle later and flags mispredictions so the pipeline can flush. It sits between the fetch stage's predictor read and the execute stage's branch comparator.

## Interface
- LOWER, 5, width of the branch-history-table index (lower PC bits)
- DEPTH, 4, number of in-flight branch entries; power of two, at least 2
- CNT_W, 16, width of the saturating statistics counters
- clk  in  1  clock, all logic on the rising edge
- arst_n  in  1  reset; synchronous, active-low
- push  in  1  fetch issued a predicted branch this cycle
- push_addr  in  LOWER  predictor index of that branch
- push_pred  in  1  prediction bit returned by the predictor
- resolve  in  1  execute resolved the oldest outstanding branch
- was_taken  in  1  conditional branch outcome
- jumped  in  1  unconditional jump resolved
- upd_branch  out  1  one-cycle strobe to the predictor update port (branch)
- upd_addr  out  LOWER  predictor write address (write_addr)
- upd_taken  out  1  registered was_taken
- upd_jumped  out  1  registered jumped
- mispredict  out  1  one-cycle pulse: popped prediction differed from the outcome
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  entries held
- mispred_cnt  out  CNT_W  saturating count of mispredictions
- resolved_cnt  out  CNT_W  saturating count of accepted resolves
- err_ovf  out  1  sticky: push was dropped because the queue was full
- err_udf  out  1  sticky: resolve arrived while the queue was empty

## Operation
- Storage: circular FIFO of DEPTH entries, each {addr[LOWER-1:0], pred}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately.
- Outcome: actual = was_taken | jumped. A popped entry mispredicts when pred != actual.
- Resolve, queue non-empty:
  - Pop the head entry.
  - Next cycle: upd_branch=1, upd_addr=head.addr, upd_taken=was_taken, upd_jumped=jumped.
  - resolved_cnt increments.
  - On a mispredict: mispredict=1, mispred_cnt increments, and the queue is flushed (pointers equal, count=0). All entries younger than the popped one belong to the wrong path and are discarded.
- Resolve, queue empty: no pop and no update strobe; set err_udf.
- Push acceptance: a push is accepted when count < DEPTH, or when a non-mispredicting resolve pops in the same cycle.
- Push during a mispredict: a push in the same cycle as a mispredicting resolve is discarded, because it is wrong-path. This is not an overflow.
- Push dropped while full: a push that is otherwise rejected when full is dropped, the queue is unchanged, and err_ovf is set.
- Simultaneous push and resolve, no mispredict: the pop and the push both occur, and count is unchanged.
- Saturation: both counters saturate at all-ones and never wrap.
- Sticky flags: err_ovf and err_udf clear only on reset.

## Timing
- Reset: with arst_n=0 at a rising edge, on the next cycle:
  - count=0, empty=1, full=0, both pointers 0.
  - upd_branch=0, upd_addr=0, upd_taken=0, upd_jumped=0, mispredict=0.
  - mispred_cnt=0, resolved_cnt=0, err_ovf=0, err_udf=0.
- Reset mid-operation discards all entries. Any resolve or push in the reset cycle is ignored.
- Registered outputs: upd_* and mispredict are registered, so resolve in cycle N gives a strobe/pulse in cycle N+1.
  - Back-to-back resolves give back-to-back strobes.
  - upd_addr, upd_taken and upd_jumped hold their last value while upd_branch=0.
- Queue status: full, empty and count reflect the registered queue state; a push in cycle N is visible in cycle N+1.
- Statistics: counters and sticky flags update at the edge ending the triggering cycle.
- Push-to-resolve: an entry pushed in cycle N may be resolved no earlier than cycle N+1.

## Test plan
- Reset with queue full and counters non-zero -> all outputs at their reset values on the next cycle; empty=1.
- Correct predictions:
  - Push addr=3 pred=1, then addr=7 pred=0.
  - Resolve was_taken=1, then resolve was_taken=0.
  - -> upd_branch strobes with upd_addr=3 then 7; mispredict stays 0; resolved_cnt=2; empty=1.
- Misprediction flush:
  - Push addr=1 pred=0, addr=2 pred=1, addr=4 pred=1.
  - Resolve jumped=1 (mispredict) with a simultaneous push of addr=9.
  - -> next cycle upd_addr=1, upd_jumped=1, mispredict=1, mispred_cnt=1, count=0; addr=9 is discarded and err_ovf stays 0.
- Wrap and full at DEPTH=4:
  - Push 4 entries -> full=1.
  - Resolve (correct) with a simultaneous push -> count stays 4.
  - Repeat 8 times -> FIFO order is preserved across pointer wrap.
- Error flags:
  - Push while full with no resolve -> err_ovf=1, contents unchanged.
  - Resolve while empty -> err_udf=1, upd_branch stays 0.
- Saturation: with CNT_W=2, run 5 mispredicting resolves -> mispred_cnt ends at 3.
